// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the shared-register write arbiter.
// Holds the arbiter state encoding, default sizing constants and the
// one-hot expansion helper used when turning a winner index into a grant.
package reg_arb_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 32;
  localparam int MAX_REQ   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  // Expand a requester index into a MAX_REQ-wide one-hot vector; callers
  // keep only the low N_REQ bits.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] index);
    logic [MAX_REQ-1:0] v;
    v        = '0;
    v[index] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: finds the first set bit of eligible, searching
// upward from ptr and wrapping from N-1 back to 0. Purely combinational
// so any shared-resource arbiter can drop it in front of its grant flops.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] winner,
  output logic          found
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Scan positions ptr, ptr+1, ... (mod N); the first hit wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/reg_load_arbiter.sv
// reg_load_arbiter: round-robin write arbiter in front of one shared
// load-enabled register. Grants at most one requester per cycle, drives
// the register's D/Load and returns a one-cycle ack equal to the grant.
// A requester that was just acked is masked for one cycle so others can
// be served back-to-back.
// Optional build macro REG_ARB_LOCK_EN adds the lock port and the LOCKED
// state, letting one requester keep exclusive ownership across writes.
module reg_load_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
`ifdef REG_ARB_LOCK_EN
  input  logic [N_REQ-1:0]       lock,
`endif
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       reg_D,
  output logic                   reg_Load,
  output logic                   busy
);

  localparam int PW = $clog2(N_REQ);

  arb_state_e         state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               load_q, load_d;
  logic [N_REQ-1:0]   elig;
  logic [PW-1:0]      win;
  logic               found;
  logic [MAX_REQ-1:0] oh_win;
  logic [WIDTH-1:0]   wd [N_REQ];
`ifdef REG_ARB_LOCK_EN
  logic [PW-1:0]      owner_q, owner_d;
  logic [MAX_REQ-1:0] oh_own;
`endif

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign wd[i] = wdata[i*WIDTH +: WIDTH];
  end

  // Eligibility: the requester acked this cycle sits out one cycle; while
  // locked only the owner may win, and the cycle that enters the lock
  // grants nobody (the owner is the one being acked).
  always_comb begin
    elig = req & ~gnt_q;
`ifdef REG_ARB_LOCK_EN
    oh_own = onehot(3'(owner_q));
    if (state_q == LOCKED) begin
      if (lock[owner_q]) elig = elig & oh_own[N_REQ-1:0];
    end else if (|(gnt_q & lock)) begin
      elig = '0;
    end
`endif
  end

  rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .eligible (elig),
    .ptr      (ptr_q),
    .winner   (win),
    .found    (found)
  );

  // Next-state: register the winner's grant/data and advance the pointer
  // past it; with no winner the data register simply holds.
  always_comb begin
    oh_win  = onehot(3'(win));
    gnt_d   = found ? oh_win[N_REQ-1:0] : '0;
    load_d  = found;
    data_d  = found ? wd[win] : data_q;
    ptr_d   = ptr_q;
    if (found) ptr_d = (win == PW'(N_REQ-1)) ? '0 : win + PW'(1);
    state_d = found ? GRANT : IDLE;
`ifdef REG_ARB_LOCK_EN
    owner_d = owner_q;
    if (state_q == LOCKED) begin
      if (lock[owner_q]) state_d = LOCKED;
    end else if (|(gnt_q & lock)) begin
      state_d = LOCKED;
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt_q[i]) owner_d = PW'(i);
      end
    end
`endif
  end

  // Arbiter state and output registers; clear returns everything to idle.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      load_q  <= 1'b0;
      data_q  <= '0;
`ifdef REG_ARB_LOCK_EN
      owner_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      load_q  <= load_d;
      data_q  <= data_d;
`ifdef REG_ARB_LOCK_EN
      owner_q <= owner_d;
`endif
    end
  end

  assign gnt      = gnt_q;
  assign ack      = gnt_q;
  assign reg_D    = data_q;
  assign reg_Load = load_q;
  assign busy     = (|gnt_q) || (state_q == LOCKED);

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Bench for reg_load_arbiter (N_REQ=4, WIDTH=32) with a model of the
// shared register on its outputs. A reference model predicts each cycle's
// outputs when stimulus is applied; predictions are queued and compared
// after the clock edge, alongside directed checks from the test plan.
module tb_reg_load_arbiter;

  logic         clk = 1'b0;
  logic         clear;
  logic [3:0]   req;
  logic [127:0] wdata;
`ifdef REG_ARB_LOCK_EN
  logic [3:0]   lock;
`endif
  logic [3:0]   gnt, ack;
  logic [31:0]  reg_D;
  logic         reg_Load, busy;
  logic [31:0]  q_reg;

  typedef struct {
    logic [3:0]  gnt;
    logic [31:0] d;
    logic        load;
    logic        busy;
    logic [31:0] q;
  } exp_t;

  exp_t exp_q[$];

  logic [3:0]  m_gnt = 4'b0;
  logic [31:0] m_D   = 32'b0;
  int          m_ptr = 0;
  logic        m_lk  = 1'b0;
  int          m_own = 0;
  logic [31:0] m_q   = 32'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_load_arbiter #(.N_REQ(4), .WIDTH(32)) dut (
    .clk      (clk),
    .clear    (clear),
    .req      (req),
    .wdata    (wdata),
`ifdef REG_ARB_LOCK_EN
    .lock     (lock),
`endif
    .gnt      (gnt),
    .ack      (ack),
    .reg_D    (reg_D),
    .reg_Load (reg_Load),
    .busy     (busy)
  );

  // Shared register: clear on the same net wins over Load.
  always_ff @(posedge clk) begin
    if (clear)         q_reg <= '0;
    else if (reg_Load) q_reg <= reg_D;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, want);
    end
  endtask

  // Predict the outputs the next edge should produce, then clock and compare.
  task automatic tick();
    exp_t        e;
    logic [3:0]  el;
    int          w;
    logic        nlk;
    int          nown;
    logic [31:0] nq;
    nq = clear ? 32'd0 : ((m_gnt != 4'b0) ? m_D : m_q);
    if (clear) begin
      m_gnt = 4'b0; m_D = 32'b0; m_ptr = 0; m_lk = 1'b0;
    end else begin
      el   = req & ~m_gnt;
      nlk  = 1'b0;
      nown = m_own;
`ifdef REG_ARB_LOCK_EN
      if (m_lk && lock[m_own]) begin
        el  = el & (4'b0001 << m_own);
        nlk = 1'b1;
      end else if (!m_lk && (m_gnt & lock) != 4'b0) begin
        el  = 4'b0;
        nlk = 1'b1;
        for (int k = 0; k < 4; k++) if (m_gnt[k]) nown = k;
      end
`endif
      w = -1;
      for (int k = 0; k < 4; k++) begin
        if (w < 0 && el[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      end
      if (w >= 0) begin
        m_gnt = 4'b0001 << w;
        m_D   = wdata[w*32 +: 32];
        m_ptr = (w + 1) % 4;
      end else begin
        m_gnt = 4'b0;
      end
      m_lk  = nlk;
      m_own = nown;
    end
    m_q    = nq;
    e.gnt  = m_gnt;
    e.d    = m_D;
    e.load = (m_gnt != 4'b0);
    e.busy = (m_gnt != 4'b0) || m_lk;
    e.q    = nq;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("sb_gnt",  32'(gnt),      32'(e.gnt));
    check("sb_ack",  32'(ack),      32'(e.gnt));
    check("sb_load", 32'(reg_Load), 32'(e.load));
    check("sb_D",    reg_D,         e.d);
    check("sb_busy", 32'(busy),     32'(e.busy));
    check("sb_Q",    q_reg,         e.q);
  endtask

  initial begin
    int acks;
    logic [3:0] rr_exp [5];
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    clear = 1'b1;
    req   = 4'b1111;
    wdata = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
`ifdef REG_ARB_LOCK_EN
    lock  = 4'b0;
`endif
    @(negedge clk);

    // Reset with all requesters asking.
    repeat (2) begin
      tick();
      check("rst_gnt",  32'(gnt),      32'h0);
      check("rst_load", 32'(reg_Load), 32'h0);
      check("rst_D",    reg_D,         32'h0);
    end

    // Contention from ptr=0: strict rotation, one write per cycle.
    clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr_gnt", 32'(gnt), 32'(rr_exp[i]));
    end
    req = 4'b0;
    repeat (2) tick();

    // Single write.
    wdata = '0;
    wdata[2*32 +: 32] = 32'hDEADBEEF;
    req = 4'b0100;
    tick();
    check("sw_gnt",  32'(gnt),      32'h4);
    check("sw_load", 32'(reg_Load), 32'h1);
    check("sw_D",    reg_D,         32'hDEADBEEF);
    req = 4'b0;
    tick();
    check("sw_Q",    q_reg,         32'hDEADBEEF);

    // Held request: the ack mask gives one write every other cycle.
    wdata[1*32 +: 32] = 32'hA5A50001;
    req  = 4'b0010;
    acks = 0;
    repeat (6) begin
      tick();
      if (ack[1]) acks++;
    end
    check("held_acks", 32'(acks), 32'd3);
    req = 4'b0;
    tick();

    // Clear in the same cycle as reg_Load.
    wdata[3*32 +: 32] = 32'hCAFEF00D;
    req = 4'b1000;
    tick();
    check("cm_load", 32'(reg_Load), 32'h1);
    clear = 1'b1;
    req   = 4'b0;
    tick();
    check("cm_gnt",  32'(gnt),      32'h0);
    check("cm_load", 32'(reg_Load), 32'h0);
    check("cm_D",    reg_D,         32'h0);
    check("cm_busy", 32'(busy),     32'h0);
    check("cm_Q",    q_reg,         32'h0);
    clear = 1'b0;

`ifdef REG_ARB_LOCK_EN
    // Lock: requester 0 keeps ownership for three writes, then 1 is served.
    wdata = {32'h0, 32'h0, 32'hBBBB0001, 32'hAAAA0000};
    req  = 4'b0011;
    lock = 4'b0001;
    tick(); check("lk_g1", 32'(gnt), 32'h1);
    tick(); check("lk_m1", 32'(gnt), 32'h0);
    check("lk_busy", 32'(busy), 32'h1);
    tick(); check("lk_g2", 32'(gnt), 32'h1);
    tick(); check("lk_m2", 32'(gnt), 32'h0);
    tick(); check("lk_g3", 32'(gnt), 32'h1);
    lock = 4'b0;
    tick(); check("lk_exit", 32'(gnt), 32'h2);
    req = 4'b0;
    repeat (2) tick();
`endif

    // Random traffic against the model, with occasional clears.
    for (int i = 0; i < 60; i++) begin
      req   = 4'($urandom_range(0, 15));
      wdata = {$urandom, $urandom, $urandom, $urandom};
      clear = ($urandom_range(0, 19) == 0);
      tick();
    end
    clear = 1'b0;
    req   = 4'b0;
    tick();

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
